// File: rtl/audio_avg_pkg.sv
// Shared types for the audio averaging scheduler: FSM state
// encoding, default sample width and the signed sample type.
package audio_avg_pkg;

   localparam int DATA_WIDTH_DEF = 24;

   typedef logic signed [DATA_WIDTH_DEF-1:0] sample_t;

   typedef enum logic [2:0] {
      IDLE,
      CAPTURE,
      FILT_L,
      WAIT_L,
      FILT_R,
      WAIT_R,
      OUTPUT
   } state_t;

endpackage

// File: rtl/audio_avg_sched_if.sv
// Codec + shared datapath bus of the averaging scheduler.
// master: scheduler side (drives read/write/wr_*/dp_start/dp_chan/dp_sample)
// slave : codec/datapath side (drives *_ready, rd_*, dp_done, dp_result)
interface audio_avg_sched_if
   import audio_avg_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

   logic                         read_ready;
   logic                         write_ready;
   logic signed [DATA_WIDTH-1:0] rd_left;
   logic signed [DATA_WIDTH-1:0] rd_right;
   logic                         read;
   logic                         write;
   logic signed [DATA_WIDTH-1:0] wr_left;
   logic signed [DATA_WIDTH-1:0] wr_right;
   logic                         dp_start;
   logic                         dp_chan;
   logic signed [DATA_WIDTH-1:0] dp_sample;
   logic                         dp_done;
   logic signed [DATA_WIDTH-1:0] dp_result;

   modport master (
      input  read_ready, write_ready, rd_left, rd_right,
      input  dp_done, dp_result,
      output read, write, wr_left, wr_right,
      output dp_start, dp_chan, dp_sample
   );

   modport slave (
      output read_ready, write_ready, rd_left, rd_right,
      output dp_done, dp_result,
      input  read, write, wr_left, wr_right,
      input  dp_start, dp_chan, dp_sample
   );

endinterface

// File: rtl/fill_counter.sv
// Saturating count of completed filtered pairs (LOGN+1 bits).
// Ports: clk, reset (async high), inc, clear; full = count reached 2^LOGN.
module fill_counter #(
   parameter int LOGN = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clear,
   output logic full
);

   localparam logic [LOGN:0] FULL_CNT = {1'b1, {LOGN{1'b0}}};

   logic [LOGN:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (inc && (cnt != FULL_CNT)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign full = (cnt == FULL_CNT);

endmodule

// File: rtl/audio_avg_sched.sv
// Schedules codec sample pairs through a shared averaging datapath.
// Ports: clk, reset (async high), bus (audio_avg_sched_if.master),
//   bypass (skip datapath), busy (not IDLE), dp_err (sticky timeout,
//   only with AUDIO_AVG_SCHED_TIMEOUT_EN defined).
module audio_avg_sched
   import audio_avg_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int LOGN       = 5,
   parameter int DP_TIMEOUT = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   audio_avg_sched_if.master         bus,
   input  logic                      bypass,
`ifdef AUDIO_AVG_SCHED_TIMEOUT_EN
   output logic                      dp_err,
`endif
   output logic                      busy
);

   if (DP_TIMEOUT < 1) begin : g_bad_timeout
      $error("DP_TIMEOUT must be at least 1");
   end

   state_t                       state;
   logic signed [DATA_WIDTH-1:0] in_r;
   logic signed [DATA_WIDTH-1:0] res_l;
   logic signed [DATA_WIDTH-1:0] res_r;
   logic                         byp_q;
   logic                         in_wait;
   logic                         timeout;
   logic                         advance;
   logic                         fill_inc;
   logic                         fill_full;

   assign in_wait  = (state == WAIT_L) || (state == WAIT_R);
   assign advance  = in_wait && (bus.dp_done || timeout);
   assign fill_inc = (state == WAIT_R) && advance;
   assign busy     = (state != IDLE);

`ifdef AUDIO_AVG_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(DP_TIMEOUT + 1) + 1;

   logic [TW-1:0] wait_cnt;

   assign timeout = in_wait && !bus.dp_done &&
                    (wait_cnt == TW'(DP_TIMEOUT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt <= '0;
         dp_err   <= 1'b0;
      end else begin
         if (in_wait && !advance) begin
            wait_cnt <= wait_cnt + 1'b1;
         end else begin
            wait_cnt <= '0;
         end
         if (timeout) begin
            dp_err <= 1'b1;
         end
      end
   end
`else
   assign timeout = 1'b0;
`endif

   fill_counter #(
      .LOGN (LOGN)
   ) u_fill (
      .clk   (clk),
      .reset (reset),
      .inc   (fill_inc),
      .clear (1'b0),
      .full  (fill_full)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         bus.read      <= 1'b0;
         bus.write     <= 1'b0;
         bus.dp_start  <= 1'b0;
         bus.dp_chan   <= 1'b0;
         bus.dp_sample <= '0;
         bus.wr_left   <= '0;
         bus.wr_right  <= '0;
         in_r          <= '0;
         res_l         <= '0;
         res_r         <= '0;
         byp_q         <= 1'b0;
      end else begin
         bus.read     <= 1'b0;
         bus.write    <= 1'b0;
         bus.dp_start <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.read_ready) begin
                  state    <= CAPTURE;
                  bus.read <= 1'b1;
               end
            end
            CAPTURE: begin
               in_r  <= bus.rd_right;
               byp_q <= bypass;
               if (bypass) begin
                  res_l <= bus.rd_left;
                  res_r <= bus.rd_right;
                  state <= OUTPUT;
               end else begin
                  bus.dp_start  <= 1'b1;
                  bus.dp_chan   <= 1'b0;
                  bus.dp_sample <= bus.rd_left;
                  state         <= FILT_L;
               end
            end
            FILT_L: state <= WAIT_L;
            WAIT_L: begin
               if (advance) begin
                  // a timed-out channel yields silence
                  res_l         <= timeout ? '0 : bus.dp_result;
                  bus.dp_start  <= 1'b1;
                  bus.dp_chan   <= 1'b1;
                  bus.dp_sample <= in_r;
                  state         <= FILT_R;
               end
            end
            FILT_R: state <= WAIT_R;
            WAIT_R: begin
               if (advance) begin
                  res_r <= timeout ? '0 : bus.dp_result;
                  state <= OUTPUT;
               end
            end
            OUTPUT: begin
               if (bus.write_ready) begin
                  // fill_full already counts this pair here
                  bus.write    <= 1'b1;
                  bus.wr_left  <= (byp_q || fill_full) ? res_l : '0;
                  bus.wr_right <= (byp_q || fill_full) ? res_r : '0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_audio_avg_sched.sv
// Directed bench for audio_avg_sched: bypass, fill warm-up,
// stray dp_done, output backpressure, mid-flight reset, timeout.
module tb_audio_avg_sched;
   import audio_avg_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic bypass;
   logic busy;
`ifdef AUDIO_AVG_SCHED_TIMEOUT_EN
   logic dp_err;
`endif
   logic auto_en;
   logic dp_auto;
   logic dp_man;
   int   checks = 0;
   int   errors = 0;

   audio_avg_sched_if dif ();

   assign dif.dp_done = dp_auto | dp_man;

   audio_avg_sched dut (
      .clk    (clk),
      .reset  (reset),
      .bus    (dif),
      .bypass (bypass),
`ifdef AUDIO_AVG_SCHED_TIMEOUT_EN
      .dp_err (dp_err),
`endif
      .busy   (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // datapath answers one cycle after dp_start when auto_en is set
   initial begin
      logic s;
      dp_auto = 1'b0;
      forever begin
         @(negedge clk);
         s = dif.dp_start && auto_en;
         @(posedge clk);
         #1;
         dp_auto = s;
      end
   end

   task automatic run_pair(input sample_t l, input sample_t r,
                           input logic byp, output int lat);
      int n;
      dif.rd_left    = l;
      dif.rd_right   = r;
      bypass         = byp;
      dif.read_ready = 1'b1;
      n = 0;
      while (!dif.read && n < 20) begin
         tick();
         n++;
      end
      dif.read_ready = 1'b0;
      chk("read_seen", dif.read, 1);
      chk("no_wr_on_rd", dif.write, 0);
      lat = 0;
      while (!dif.write && lat < 200) begin
         tick();
         lat++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int nwr;
      reset           = 1'b1;
      bypass          = 1'b0;
      auto_en         = 1'b0;
      dp_man          = 1'b0;
      dif.read_ready  = 1'b0;
      dif.write_ready = 1'b1;
      dif.rd_left     = '0;
      dif.rd_right    = '0;
      dif.dp_result   = '0;
      repeat (3) tick();
      chk("rst_ctl", {dif.read, dif.write, dif.dp_start, dif.dp_chan, busy}, 0);
      chk("rst_dps", dif.dp_sample, 0);
      chk("rst_wr", {dif.wr_left, dif.wr_right}, 0);
      reset = 1'b0;
      tick();

      // bypass pair: 2-cycle latency, raw samples out
      run_pair(24'sd4, 24'sd16, 1'b1, lat);
      chk("byp_lat", lat, 2);
      chk("byp_wl", dif.wr_left, 4);
      chk("byp_wr", dif.wr_right, 16);

      // stray dp_done while idle
      dif.dp_result = 24'sd99;
      dp_man = 1'b1;
      tick();
      dp_man = 1'b0;
      tick();
      chk("idle_done_busy", busy, 0);
      chk("idle_done_wr", {dif.wr_left, dif.wr_right}, {24'sd4, 24'sd16});

      // warm-up: 31 filtered pairs silenced, a bypass pair mixed in
      auto_en = 1'b1;
      dif.dp_result = 24'sd7;
      for (int i = 1; i <= 31; i++) begin
         run_pair(sample_t'(i), sample_t'(-i), 1'b0, lat);
         chk("warm_lat", lat, 6);
         chk("warm_out", {dif.wr_left, dif.wr_right}, 0);
         if (i == 16) begin
            run_pair(24'sd100, -24'sd100, 1'b1, lat);
            chk("mid_byp_wl", dif.wr_left, 100);
            chk("mid_byp_wr", dif.wr_right, -100);
         end
      end
      run_pair(24'sd32, 24'sd33, 1'b0, lat);
      chk("full_wl", dif.wr_left, 7);
      chk("full_wr", dif.wr_right, 7);
      dif.dp_result = -24'sd5;
      run_pair(24'sd1, 24'sd2, 1'b0, lat);
      chk("neg_wl", dif.wr_left, -5);
      chk("neg_wr", dif.wr_right, -5);

      // backpressure in OUTPUT plus stray dp_done there
      dif.write_ready = 1'b0;
      dif.dp_result   = 24'sd55;
      dif.rd_left     = 24'sd11;
      dif.rd_right    = 24'sd22;
      bypass          = 1'b1;
      dif.read_ready  = 1'b1;
      nwr = 0;
      while (!dif.read && nwr < 20) begin
         tick();
         nwr++;
      end
      dif.read_ready = 1'b0;
      chk("bp_read", dif.read, 1);
      tick();
      dp_man = 1'b1;
      tick();
      dp_man = 1'b0;
      for (int k = 0; k < 9; k++) begin
         chk("bp_write", dif.write, 0);
         chk("bp_busy", busy, 1);
         chk("bp_hold", {dif.wr_left, dif.wr_right}, {-24'sd5, -24'sd5});
         tick();
      end
      dif.write_ready = 1'b1;
      tick();
      chk("bp_fire", dif.write, 1);
      chk("bp_wl", dif.wr_left, 11);
      chk("bp_wr", dif.wr_right, 22);
      tick();
      chk("bp_one", dif.write, 0);
      chk("bp_keep", {dif.wr_left, dif.wr_right}, {24'sd11, 24'sd22});

      // reset while waiting on the right channel
      auto_en        = 1'b0;
      dif.dp_result  = 24'sd9;
      dif.rd_left    = 24'sd5;
      dif.rd_right   = 24'sd6;
      bypass         = 1'b0;
      dif.read_ready = 1'b1;
      nwr = 0;
      while (!dif.read && nwr < 20) begin
         tick();
         nwr++;
      end
      dif.read_ready = 1'b0;
      tick();
      chk("fl_start", dif.dp_start, 1);
      chk("fl_chan", dif.dp_chan, 0);
      chk("fl_samp", dif.dp_sample, 5);
      tick();
      chk("wl_start", dif.dp_start, 0);
      chk("wl_samp", {dif.dp_chan, dif.dp_sample}, {1'b0, 24'sd5});
      dp_man = 1'b1;
      tick();
      dp_man = 1'b0;
      chk("fr_start", dif.dp_start, 1);
      chk("fr_samp", {dif.dp_chan, dif.dp_sample}, {1'b1, 24'sd6});
      tick();
      chk("wr_busy", busy, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("mr_ctl", {dif.read, dif.write, dif.dp_start, dif.dp_chan, busy}, 0);
      chk("mr_dps", dif.dp_sample, 0);
      chk("mr_wr", {dif.wr_left, dif.wr_right}, 0);
      tick();
      reset = 1'b0;
      nwr = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (dif.write) nwr++;
      end
      chk("mr_nowrite", nwr, 0);
      chk("mr_idle", busy, 0);

      // fill count restarted by reset
      auto_en = 1'b1;
      dif.dp_result = 24'sd7;
      run_pair(24'sd3, 24'sd4, 1'b0, lat);
      chk("refill_lat", lat, 6);
      chk("refill_out", {dif.wr_left, dif.wr_right}, 0);

`ifdef AUDIO_AVG_SCHED_TIMEOUT_EN
      chk("err_clear", dp_err, 0);
      auto_en = 1'b0;
      run_pair(24'sd8, 24'sd9, 1'b0, lat);
      chk("to_done", (lat < 200), 1);
      chk("to_err", dp_err, 1);
      chk("to_wl", dif.wr_left, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
